// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM
//
// Sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared memory and ALU and
// drives the per-state datapath enables, mux selects and ALU control.
//
// Parameters:
//   ALU_CTRL_W      3 = add/sub/and/or/slt, 4 = full RV32I ALU set (3 or 4 only)
//   EXT_BRANCH      1 = also decode bne (f3=001)
//   TRAP_ON_ILLEGAL 1 = illegal instruction parks the FSM in TRAP,
//                   0 = flag it for the DECODE cycle and return to FETCH
//
// Ports:
//   clk, reset         clock (rising edge), synchronous active-high reset
//   op, f3, f7, zero   opcode, funct3, funct7 (bit 5 only), ALU zero flag
//   pcWrite, adrSrc, memWrite, irWrite, regWrite   datapath enables / selects
//   resSrc, aluSrcA, aluSrcB, immSrc               datapath mux selects
//   aluControl         ALU operation
//   illegal            illegal instruction flag
//   state              current FSM state (debug)

module multicycle_control_unit #(
  parameter int ALU_CTRL_W      = 3,
  parameter bit EXT_BRANCH      = 1'b0,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            f3,
  input  logic [6:0]            f7,
  input  logic                  zero,
  output logic                  pcWrite,
  output logic                  adrSrc,
  output logic                  memWrite,
  output logic                  irWrite,
  output logic [1:0]            resSrc,
  output logic [1:0]            aluSrcA,
  output logic [1:0]            aluSrcB,
  output logic [1:0]            immSrc,
  output logic                  regWrite,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  illegal,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // The 3-bit encodings are the low bits of the 4-bit ones, so the ALU control
  // is always built at 4 bits and truncated to the configured width.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam bit FULL_ALU = (ALU_CTRL_W >= 4);

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec_state;
  logic [1:0] w_alu_op;
  logic [3:0] w_funct_ctrl;
  logic [3:0] w_alu_ctrl4;
  logic       w_op_illegal;
  logic       w_unused_f7;

  assign w_unused_f7 = &{1'b0, f7[6], f7[4:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign state = r_state;

  // While reset is held the datapath sees FETCH decode, so a reset in the
  // middle of an instruction changes the mux selects in the same cycle.
  assign w_dec_state = reset ? S_FETCH : r_state;

  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BR:   immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // Opcode / funct3 combinations this configuration cannot execute.
  always_comb begin
    w_op_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_JAL: w_op_illegal = 1'b0;
      OP_R, OP_I: begin
        if (!FULL_ALU && (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b100 || f3 == 3'b101))
          w_op_illegal = 1'b1;
      end
      OP_BR: begin
        if (!(f3 == 3'b000 || (EXT_BRANCH && f3 == 3'b001)))
          w_op_illegal = 1'b1;
      end
      default: w_op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_funct_ctrl = ALU_ADD;
    case (f3)
      // Only R-type (op[5]=1) can subtract; addi with imm[10]=1 stays add.
      3'b000: w_funct_ctrl = (op[5] & f7[5]) ? ALU_SUB : ALU_ADD;
      3'b010: w_funct_ctrl = ALU_SLT;
      3'b110: w_funct_ctrl = ALU_OR;
      3'b111: w_funct_ctrl = ALU_AND;
      3'b001: if (FULL_ALU) w_funct_ctrl = ALU_SLL;
      3'b011: if (FULL_ALU) w_funct_ctrl = ALU_SLTU;
      3'b100: if (FULL_ALU) w_funct_ctrl = ALU_XOR;
      3'b101: if (FULL_ALU) w_funct_ctrl = f7[5] ? ALU_SRA : ALU_SRL;
      default: w_funct_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    case (w_alu_op)
      ALUOP_SUB:   w_alu_ctrl4 = ALU_SUB;
      ALUOP_FUNCT: w_alu_ctrl4 = w_funct_ctrl;
      default:     w_alu_ctrl4 = ALU_ADD;
    endcase
  end

  assign aluControl = w_alu_ctrl4[ALU_CTRL_W-1:0];

  always_comb begin
    w_next   = w_dec_state;
    pcWrite  = 1'b0;
    adrSrc   = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    regWrite = 1'b0;
    illegal  = 1'b0;
    resSrc   = 2'b00;
    aluSrcA  = 2'b00;
    aluSrcB  = 2'b00;
    w_alu_op = ALUOP_ADD;

    case (w_dec_state)
      S_FETCH: begin
        irWrite = 1'b1;
        pcWrite = 1'b1;
        aluSrcB = 2'b10;
        resSrc  = 2'b10;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes the branch/jump target from oldPC + imm meanwhile.
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        illegal = w_op_illegal;
        if (w_op_illegal) begin
          w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_R:         w_next = S_EXECR;
            OP_I:         w_next = S_EXECI;
            OP_JAL:       w_next = S_JAL;
            default:      w_next = S_BRANCH;
          endcase
        end
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        resSrc   = 2'b01;
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA  = 2'b10;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA  = 2'b10;
        aluSrcB  = 2'b01;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA  = 2'b10;
        w_alu_op = ALUOP_SUB;
        pcWrite  = ((f3 == 3'b000) & zero) |
                   (EXT_BRANCH & (f3 == 3'b001) & ~zero);
        w_next   = S_FETCH;
      end
      S_JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase

    if (reset) begin
      pcWrite  = 1'b0;
      irWrite  = 1'b0;
      memWrite = 1'b0;
      regWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - bench for multicycle_control_unit
//
// Two instances share all inputs:
//   A: ALU_CTRL_W=3, EXT_BRANCH=0, TRAP_ON_ILLEGAL=1
//   B: ALU_CTRL_W=4, EXT_BRANCH=1, TRAP_ON_ILLEGAL=0
// Each observation vector is
//   {state, pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal,
//    resSrc, aluSrcA, aluSrcB, immSrc, aluControl(4b)}

module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       zero;

  logic       pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a;
  logic [1:0] res_a, sa_a, sb_a, imm_a;
  logic [2:0] alu_a;
  logic [3:0] st_a;
  logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b;
  logic [1:0] res_b, sa_b, sb_b, imm_b;
  logic [3:0] alu_b;
  logic [3:0] st_b;

  multicycle_control_unit #(.ALU_CTRL_W(3), .EXT_BRANCH(1'b0), .TRAP_ON_ILLEGAL(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .pcWrite(pcw_a), .adrSrc(adr_a), .memWrite(mw_a), .irWrite(irw_a),
    .resSrc(res_a), .aluSrcA(sa_a), .aluSrcB(sb_a), .immSrc(imm_a),
    .regWrite(rw_a), .aluControl(alu_a), .illegal(ill_a), .state(st_a)
  );

  multicycle_control_unit #(.ALU_CTRL_W(4), .EXT_BRANCH(1'b1), .TRAP_ON_ILLEGAL(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
    .pcWrite(pcw_b), .adrSrc(adr_b), .memWrite(mw_b), .irWrite(irw_b),
    .resSrc(res_b), .aluSrcA(sa_b), .aluSrcB(sb_b), .immSrc(imm_b),
    .regWrite(rw_b), .aluControl(alu_b), .illegal(ill_b), .state(st_b)
  );

  wire [21:0] obs_a = {st_a, pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a,
                       res_a, sa_a, sb_a, imm_a, 1'b0, alu_a};
  wire [21:0] obs_b = {st_b, pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b,
                       res_b, sa_b, sb_b, imm_b, alu_b};

  logic [21:0] qa[$];
  logic [21:0] qb[$];
  logic [21:0] ea, eb;
  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal}
  function automatic logic [21:0] rec(input logic [3:0] st, input logic [5:0] en,
                                      input logic [1:0] res, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] imm,
                                      input logic [3:0] alu);
    return {st, en, res, sa, sb, imm, alu};
  endfunction

  function automatic logic [21:0] e_fetch(input logic [1:0] imm);
    return rec(4'd0, 6'b100100, 2'b10, 2'b00, 2'b10, imm, 4'd0);
  endfunction

  function automatic logic [21:0] e_decode(input logic [1:0] imm, input logic ill);
    return rec(4'd1, {5'b0, ill}, 2'b00, 2'b01, 2'b01, imm, 4'd0);
  endfunction

  function automatic logic [21:0] e_trap(input logic [1:0] imm);
    return rec(4'd15, 6'b000001, 2'b00, 2'b00, 2'b00, imm, 4'd0);
  endfunction

  task automatic push2(input logic [21:0] a, input logic [21:0] b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] fn3,
                           input logic [6:0] fn7, input logic z);
    op = o; f3 = fn3; f7 = fn7; zero = z;
  endtask

  task automatic resync;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_instr(OP_LW, 3'b010, 7'd0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      push2(rec(4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 4'd0),
            rec(4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL reset_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL reset_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_lw;
    set_instr(OP_LW, 3'b010, 7'd0, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b0), e_decode(2'b00, 1'b0));
    push2(rec(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'd0), rec(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'd0));
    push2(rec(4'd3, 6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0), rec(4'd3, 6'b010000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0));
    push2(rec(4'd4, 6'b000010, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0), rec(4'd4, 6'b000010, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL lw_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL lw_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw;
    set_instr(OP_SW, 3'b010, 7'd0, 1'b1);
    push2(e_fetch(2'b01), e_fetch(2'b01));
    push2(e_decode(2'b01, 1'b0), e_decode(2'b01, 1'b0));
    push2(rec(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 4'd0), rec(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 4'd0));
    push2(rec(4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0), rec(4'd5, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b01, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL sw_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL sw_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // R-type sub, R-type and, I-type addi with imm[10]=1 (must stay add).
  task automatic test_alu_ops;
    set_instr(OP_R, 3'b000, 7'b0100000, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b0), e_decode(2'b00, 1'b0));
    push2(rec(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001), rec(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001));
    push2(rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0), rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL rsub_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL rsub_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    set_instr(OP_R, 3'b111, 7'd0, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b0), e_decode(2'b00, 1'b0));
    push2(rec(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0010), rec(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0010));
    push2(rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0), rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0));
    set_instr(OP_I, 3'b000, 7'b0100000, 1'b0);
    cyc = 0;
    // the and-instruction records are consumed with op switched below
    set_instr(OP_R, 3'b111, 7'd0, 1'b0);
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL rand_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL rand_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    set_instr(OP_I, 3'b000, 7'b0100000, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b0), e_decode(2'b00, 1'b0));
    push2(rec(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000), rec(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0000));
    push2(rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0), rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL addi_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL addi_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      set_instr(OP_BR, 3'b000, 7'd0, z[0]);
      push2(e_fetch(2'b10), e_fetch(2'b10));
      push2(e_decode(2'b10, 1'b0), e_decode(2'b10, 1'b0));
      push2(rec(4'd9, {z[0], 5'b0}, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001),
            rec(4'd9, {z[0], 5'b0}, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001));
      cyc = 0;
      while (qa.size() > 0) begin
        @(negedge clk);
        ea = qa.pop_front(); eb = qb.pop_front();
        n_checks += 2;
        if (obs_a !== ea) begin n_errors++; $display("FAIL beq_z%0d_a cyc%0d got %h want %h", z, cyc, obs_a, ea); end
        if (obs_b !== eb) begin n_errors++; $display("FAIL beq_z%0d_b cyc%0d got %h want %h", z, cyc, obs_b, eb); end
        cyc++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal;
    set_instr(OP_JAL, 3'b101, 7'b0100000, 1'b0);
    push2(e_fetch(2'b11), e_fetch(2'b11));
    push2(e_decode(2'b11, 1'b0), e_decode(2'b11, 1'b0));
    push2(rec(4'd10, 6'b100000, 2'b00, 2'b01, 2'b10, 2'b11, 4'd0), rec(4'd10, 6'b100000, 2'b00, 2'b01, 2'b10, 2'b11, 4'd0));
    push2(rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b11, 4'd0), rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b11, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL jal_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL jal_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // bne: A (no EXT_BRANCH) traps, B takes it. blt: illegal on both.
  task automatic test_branch_ext;
    set_instr(OP_BR, 3'b001, 7'd0, 1'b0);
    push2(e_fetch(2'b10), e_fetch(2'b10));
    push2(e_decode(2'b10, 1'b1), e_decode(2'b10, 1'b0));
    push2(e_trap(2'b10), rec(4'd9, 6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0001));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL bne_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL bne_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    resync();
    set_instr(OP_BR, 3'b100, 7'd0, 1'b0);
    push2(e_fetch(2'b10), e_fetch(2'b10));
    push2(e_decode(2'b10, 1'b1), e_decode(2'b10, 1'b1));
    push2(e_trap(2'b10), e_fetch(2'b10));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL blt_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL blt_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    resync();
  endtask

  task automatic test_illegal_op;
    set_instr(OP_BAD, 3'b000, 7'd0, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b1), e_decode(2'b00, 1'b1));
    push2(e_trap(2'b00), e_fetch(2'b00));
    push2(e_trap(2'b00), e_decode(2'b00, 1'b1));
    push2(e_trap(2'b00), e_fetch(2'b00));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL badop_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL badop_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    resync();
  endtask

  // xor (R) and srai (I): only the 4-bit ALU decodes them.
  task automatic test_full_alu;
    set_instr(OP_R, 3'b100, 7'd0, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b1), e_decode(2'b00, 1'b0));
    push2(e_trap(2'b00), rec(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0100));
    push2(e_trap(2'b00), rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL xor_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL xor_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    resync();
    set_instr(OP_I, 3'b101, 7'b0100000, 1'b0);
    push2(e_fetch(2'b00), e_fetch(2'b00));
    push2(e_decode(2'b00, 1'b1), e_decode(2'b00, 1'b0));
    push2(e_trap(2'b00), rec(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'b1001));
    push2(e_trap(2'b00), rec(4'd8, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL srai_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL srai_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    resync();
  endtask

  task automatic test_reset_in_memwrite;
    set_instr(OP_SW, 3'b010, 7'd0, 1'b0);
    push2(e_fetch(2'b01), e_fetch(2'b01));
    push2(e_decode(2'b01, 1'b0), e_decode(2'b01, 1'b0));
    push2(rec(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 4'd0), rec(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 4'd0));
    cyc = 0;
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL swrst_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL swrst_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    // now in MEMWRITE: reset drops memWrite at once, outputs follow FETCH decode
    reset = 1'b1;
    push2(rec(4'd5, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b01, 4'd0), rec(4'd5, 6'b000000, 2'b10, 2'b00, 2'b10, 2'b01, 4'd0));
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL swrst_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL swrst_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    push2(e_fetch(2'b01), e_fetch(2'b01));
    while (qa.size() > 0) begin
      @(negedge clk);
      ea = qa.pop_front(); eb = qb.pop_front();
      n_checks += 2;
      if (obs_a !== ea) begin n_errors++; $display("FAIL swrst_a cyc%0d got %h want %h", cyc, obs_a, ea); end
      if (obs_b !== eb) begin n_errors++; $display("FAIL swrst_b cyc%0d got %h want %h", cyc, obs_b, eb); end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 7'd0; f3 = 3'd0; f7 = 7'd0; zero = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_beq();
    test_jal();
    test_branch_ext();
    test_illegal_op();
    test_full_alu();
    test_reset_in_memwrite();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
